// File: rtl/pid_pkg.sv
// pid_pkg: shared definitions for the incremental-PID increment stage.
//   OUT_MAX / OUT_MIN : saturation limits of the 15-bit d_uk output
//   PID_DB            : deadband magnitude, used only when PID_DEADBAND_EN is defined
//   pid_state_e       : sequencing FSM states
//   pid_acc_w()       : accumulator width that cannot overflow for given error/gain widths
package pid_pkg;

  localparam int OUT_MAX = 16383;
  localparam int OUT_MIN = -16384;
  localparam int PID_DB  = 4;

  typedef enum logic [2:0] {
    IDLE,
    MUL_P,
    MUL_I,
    MUL_D,
    SAT
  } pid_state_e;

  function automatic int pid_acc_w(input int err_w, input int gain_w);
    return err_w + gain_w + 5;
  endfunction

endpackage

// File: rtl/pid_incr_mac.sv
// pid_mac: registered signed x unsigned multiply-accumulate.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset, clears acc
//   clr_acc  in   1: acc <= a*b (start new sum), 0: acc <= acc + a*b
//   a        in   signed operand, A_W bits
//   b        in   unsigned operand (zero-extended), B_W bits
//   acc      out  signed accumulator, ACC_W bits
// Driving a=0 with clr_acc=0 holds the accumulator.
module pid_mac #(
  parameter int A_W   = 14,
  parameter int B_W   = 8,
  parameter int ACC_W = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_acc,
  input  logic signed [A_W-1:0]   a,
  input  logic        [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W + 1;

  logic signed [P_W-1:0]   a_x;
  logic signed [P_W-1:0]   b_x;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    a_x   = P_W'(a);
    b_x   = P_W'(b);
    prod  = a_x * b_x;
    acc_d = (clr_acc ? '0 : acc) + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc_d;
    end
  end

endmodule

// File: rtl/pid_incr.sv
// pid_incr: incremental-PID increment stage.
//   d_uk = Kp*(e0-e1) + Ki*e0 + Kd*(e0-2*e1+e2), scaled by 2^-FRAC (floor),
//   saturated to [OUT_MIN, OUT_MAX]. One shared MAC, sequenced
//   IDLE -> MUL_P -> MUL_I -> MUL_D -> SAT -> IDLE (one sample per 5 clocks).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pid_clr         sync clear of error history, aborts any calculation
//   kp, ki, kd      unsigned gains, sampled at accept
//   err, err_valid  signed error sample and its valid
//   err_ready       high in IDLE when pid_clr is low
//   d_uk            saturated increment, held between pulses
//   d_uk_valid      one-cycle pulse when d_uk updates
// Configuration: define PID_DEADBAND_EN to force |err| <= PID_DB to zero at accept.
module pid_incr
  import pid_pkg::*;
#(
  parameter int ERR_W  = 12,
  parameter int GAIN_W = 8,
  parameter int FRAC   = 4,
  parameter int OUT_W  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pid_clr,
  input  logic        [GAIN_W-1:0] kp,
  input  logic        [GAIN_W-1:0] ki,
  input  logic        [GAIN_W-1:0] kd,
  input  logic signed [ERR_W-1:0] err,
  input  logic                    err_valid,
  output logic                    err_ready,
  output logic signed [OUT_W-1:0] d_uk,
  output logic                    d_uk_valid
);

  localparam int ACC_W = pid_acc_w(ERR_W, GAIN_W);
  localparam int A_W   = ERR_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(OUT_MIN);

  pid_state_e               state_q;
  logic signed [ERR_W-1:0]  e0_q, e1_q, e2_q;
  logic signed [ERR_W-1:0]  e_in_d;
  // d1 needs ERR_W+1 bits; it is kept sign-extended to the MAC operand width.
  logic signed [A_W-1:0]    d1_q, d2_q, d1_d, d2_d;
  logic        [GAIN_W-1:0] kp_q, ki_q, kd_q;
  logic signed [A_W-1:0]    mac_a;
  logic        [GAIN_W-1:0] mac_b;
  logic                     mac_clr;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  y_d;
  logic signed [OUT_W-1:0]  sat_d;
  logic signed [OUT_W-1:0]  d_uk_q;
  logic                     d_uk_valid_q;

`ifdef PID_DEADBAND_EN
  localparam logic signed [ERR_W-1:0] DB_S = ERR_W'(PID_DB);
`endif

  // Sample conditioning and difference terms for the accept cycle
  always_comb begin
`ifdef PID_DEADBAND_EN
    e_in_d = (err >= -DB_S && err <= DB_S) ? '0 : err;
`else
    e_in_d = err;
`endif
    d1_d = A_W'(e_in_d) - A_W'(e1_q);
    d2_d = A_W'(e_in_d) - (A_W'(e1_q) <<< 1) + A_W'(e2_q);
  end

  // Operand mux for the shared MAC; outside the multiply states a=0 holds acc
  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_clr = 1'b0;
    case (state_q)
      MUL_P: begin
        mac_a   = d1_q;
        mac_b   = kp_q;
        mac_clr = 1'b1;
      end
      MUL_I: begin
        mac_a = A_W'(e0_q);
        mac_b = ki_q;
      end
      MUL_D: begin
        mac_a = d2_q;
        mac_b = kd_q;
      end
      default: ;
    endcase
  end

  pid_mac #(
    .A_W   (A_W),
    .B_W   (GAIN_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr_acc (mac_clr),
    .a       (mac_a),
    .b       (mac_b),
    .acc     (acc)
  );

  // Arithmetic shift floors toward -inf, then clamp
  always_comb begin
    y_d = acc >>> FRAC;
    if (y_d > SAT_HI) begin
      sat_d = OUT_W'(OUT_MAX);
    end else if (y_d < SAT_LO) begin
      sat_d = OUT_W'(OUT_MIN);
    end else begin
      sat_d = y_d[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      e0_q         <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      d_uk_q       <= '0;
      d_uk_valid_q <= 1'b0;
    end else begin
      d_uk_valid_q <= 1'b0;
      if (pid_clr) begin
        state_q <= IDLE;
        e1_q    <= '0;
        e2_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (err_valid) begin
              e0_q    <= e_in_d;
              d1_q    <= d1_d;
              d2_q    <= d2_d;
              kp_q    <= kp;
              ki_q    <= ki;
              kd_q    <= kd;
              state_q <= MUL_P;
            end
          end
          MUL_P: state_q <= MUL_I;
          MUL_I: state_q <= MUL_D;
          MUL_D: state_q <= SAT;
          SAT: begin
            d_uk_q       <= sat_d;
            d_uk_valid_q <= 1'b1;
            e2_q         <= e1_q;
            e1_q         <= e0_q;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign err_ready  = (state_q == IDLE) & ~pid_clr;
  assign d_uk       = d_uk_q;
  assign d_uk_valid = d_uk_valid_q;

endmodule
